// File: rtl/pipe_ctrl_unit_pkg.sv
// Shared types for the pipeline control unit: pipe state encoding and stage index type.
package pipe_ctrl_unit_pkg;

  localparam int STAGE_CNT = 5;
  localparam int IDX_W     = (STAGE_CNT > 1) ? $clog2(STAGE_CNT) : 1;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    HALT  = 2'd2
  } pipe_state_t;

  typedef logic [IDX_W-1:0] stage_idx_t;

endpackage

// File: rtl/pipe_ctrl_unit_if.sv
// Handshake bundle between the core's stage logic (master) and the pipeline control unit (slave).
interface pipe_ctrl_unit_if
  import pipe_ctrl_unit_pkg::*;
#(
  parameter int stage_cnt = STAGE_CNT,
  parameter int cnt_width = 32
);

  localparam int IW = (stage_cnt > 1) ? $clog2(stage_cnt) : 1;

  logic                 en;
  logic [stage_cnt-1:0] stage_rdy;
  logic [stage_cnt-1:0] stage_vld;
  logic [stage_cnt-1:0] stall_req;
  logic                 redirect_vld;
  logic [IW-1:0]        redirect_stage;
  logic                 halt_req;
  logic [stage_cnt-1:0] stage_en;
  logic [stage_cnt-1:0] stage_flush;
  pipe_state_t          state;
  logic                 halted;
  logic [cnt_width-1:0] cycle_cnt;
  logic [cnt_width-1:0] retire_cnt;

  modport master (
    output en, stage_rdy, stage_vld, stall_req, redirect_vld, redirect_stage, halt_req,
    input  stage_en, stage_flush, state, halted, cycle_cnt, retire_cnt
  );

  modport slave (
    input  en, stage_rdy, stage_vld, stall_req, redirect_vld, redirect_stage, halt_req,
    output stage_en, stage_flush, state, halted, cycle_cnt, retire_cnt
  );

endinterface

// File: rtl/pipe_ctrl_unit_perf_ctr.sv
// Active-cycle and retired-instruction counters; both wrap freely.
module pipe_perf_ctr
  import pipe_ctrl_unit_pkg::*;
#(
  parameter int cnt_width = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cyc_inc_i,
  input  logic                 ret_inc_i,
  output logic [cnt_width-1:0] cycle_cnt_o,
  output logic [cnt_width-1:0] retire_cnt_o
);

  logic [cnt_width-1:0] cyc_q, cyc_d;
  logic [cnt_width-1:0] ret_q, ret_d;

  always_comb begin
    cyc_d = cyc_q + cnt_width'(cyc_inc_i);
    ret_d = ret_q + cnt_width'(ret_inc_i);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc_q <= '0;
      ret_q <= '0;
    end else begin
      cyc_q <= cyc_d;
      ret_q <= ret_d;
    end
  end

  assign cycle_cnt_o  = cyc_q;
  assign retire_cnt_o = ret_q;

endmodule

// File: rtl/pipe_ctrl_unit.sv
// Pipeline control unit: freeze/bubble, redirect flush window, drain-and-halt FSM, perf counters.
//   state | meaning
//   RUN   | normal operation
//   DRAIN | fetch blocked (stage 0 flushed), waiting for all stages to empty
//   HALT  | pipeline empty and frozen until halt_req drops
module pipe_ctrl_unit
  import pipe_ctrl_unit_pkg::*;
#(
  parameter int stage_cnt    = STAGE_CNT,
  parameter int flush_cycles = 1,
  parameter int cnt_width    = 32
) (
  input logic            clk,
  input logic            rst,
  pipe_ctrl_unit_if.slave bus
);

  localparam int IW    = (stage_cnt > 1) ? $clog2(stage_cnt) : 1;
  localparam int WIN_W = (flush_cycles > 1) ? $clog2(flush_cycles) : 1;
  localparam logic [WIN_W-1:0] WIN_LOAD = WIN_W'(flush_cycles - 1);

  pipe_state_t          state_q, state_d;
  logic [IW-1:0]        win_stage_q, win_stage_d;
  logic [WIN_W-1:0]     win_left_q, win_left_d;

  logic                 frz_vld;
  logic [IW-1:0]        frz_idx;
  logic                 active;
  logic                 redir_take;
  logic [stage_cnt-1:0] redir_mask, win_mask, bubble, hard_flush, flush, stage_en;
  logic [cnt_width-1:0] cycle_cnt, retire_cnt;

  assign active     = bus.en && (state_q != HALT);
  assign redir_take = bus.redirect_vld && (state_q != HALT);

  // Ascending scan so the highest frozen stage wins.
  always_comb begin
    frz_vld = 1'b0;
    frz_idx = '0;
    for (int i = 0; i < stage_cnt; i++) begin
      if (bus.stall_req[i] || !bus.stage_rdy[i]) begin
        frz_vld = 1'b1;
        frz_idx = IW'(i);
      end
    end
  end

  always_comb begin
    redir_mask = '0;
    win_mask   = '0;
    bubble     = '0;
    for (int i = 0; i < stage_cnt; i++) begin
      if (redir_take && (IW'(i) < bus.redirect_stage)) redir_mask[i] = 1'b1;
      if ((win_left_q != '0) && (IW'(i) < win_stage_q)) win_mask[i] = 1'b1;
      if (frz_vld && (i == int'(frz_idx) + 1)) bubble[i] = 1'b1;
    end
    hard_flush = redir_mask | win_mask | {{(stage_cnt-1){1'b0}}, state_q == DRAIN};
    flush      = (state_q == HALT) ? '0 : (hard_flush | bubble);
  end

  // The bubble stage must stay enabled so its clear is captured; only
  // redirect/drain flushes override the enable.
  always_comb begin
    stage_en = '0;
    for (int i = 0; i < stage_cnt; i++) begin
      stage_en[i] = active && !(frz_vld && (i <= int'(frz_idx))) && !hard_flush[i];
    end
  end

  always_comb begin
    win_stage_d = win_stage_q;
    win_left_d  = win_left_q;
    if (bus.en) begin
      if (redir_take) begin
        win_stage_d = bus.redirect_stage;
        win_left_d  = WIN_LOAD;
      end else if (win_left_q != '0) begin
        win_left_d = win_left_q - 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    if (bus.en) begin
      case (state_q)
        RUN:     if (bus.halt_req) state_d = DRAIN;
        DRAIN: begin
          if (!bus.halt_req)            state_d = RUN;
          else if (bus.stage_vld == '0) state_d = HALT;
        end
        HALT:    if (!bus.halt_req) state_d = RUN;
        default: state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= RUN;
      win_stage_q <= '0;
      win_left_q  <= '0;
    end else begin
      state_q     <= state_d;
      win_stage_q <= win_stage_d;
      win_left_q  <= win_left_d;
    end
  end

  pipe_perf_ctr #(.cnt_width(cnt_width)) u_perf (
    .clk          (clk),
    .rst          (rst),
    .cyc_inc_i    (active),
    .ret_inc_i    (bus.stage_vld[stage_cnt-1] && stage_en[stage_cnt-1]),
    .cycle_cnt_o  (cycle_cnt),
    .retire_cnt_o (retire_cnt)
  );

  assign bus.stage_en    = rst ? '0 : stage_en;
  assign bus.stage_flush = rst ? '1 : flush;
  assign bus.state       = state_q;
  assign bus.halted      = (state_q == HALT);
  assign bus.cycle_cnt   = cycle_cnt;
  assign bus.retire_cnt  = retire_cnt;

endmodule
